mem_dmem: RTL
=============

Name: mem_dmem

Overview:
Data memory for the MEM stage of the single-cycle/pipelined RV32 core. It takes the EX-stage address, store data and MEM control, and performs byte, half-word and word loads/stores with sign or zero extension. Loads are combinational; stores commit on the clock edge. Its o_readData is the value the MEM-stage transaction logger and the WB mux consume. It also keeps a sticky access-fault record and the access counters used by sim/debug.

Parameters:
DEPTH_WORDS, 2048, number of 32-bit words; word index = addr[ADDR_W+1:2], ADDR_W = $clog2(DEPTH_WORDS) (11 → addr[12:2]).
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_memAddr  in  32  byte address
i_writeData  in  32  store data, LSB-justified (SB uses [7:0], SH uses [15:0])
i_ctrlMEM  in  mem_ctrl_t (2)  [1]=read, [0]=write
i_funct3  in  3  access size/sign (RV32 load/store funct3)
o_readData  out  32  extended load data
o_accessFault  out  1  combinational fault for the current access
o_faultSticky  out  1  registered; set by first fault since reset
o_faultAddr  out  32  registered; address of first fault
o_readCount  out  32  successful loads since reset
o_writeCount  out  32  successful stores since reset

Behaviour:
- Reset is i_reset_n, synchronous, active-low, on clock i_clk. On a reset edge: o_faultSticky=0, o_faultAddr=0, o_readCount=0, o_writeCount=0. Memory contents are not cleared. Stores are suppressed in any cycle with i_reset_n=0.
- Offset = i_memAddr - BASE_ADDR, computed in 32-bit unsigned arithmetic. In range iff offset < DEPTH_WORDS*4. Below-base addresses wrap to a large offset and therefore fault.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other code is illegal for that direction.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- o_accessFault = (read|write) & (out-of-range | illegal funct3 | misaligned | (read & write)). It is 0 when ctrl=00.
- Loads are combinational, with zero latency. When read & !fault: select the byte lane addr[1:0] or the half lane addr[1], then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW returns the full word. Otherwise o_readData=32'h0.
- Stores commit at posedge when i_reset_n & write & !fault, using byte enables:
  - SB: 1 lane, at lane addr[1:0].
  - SH: 2 lanes, at addr[1]*2.
  - SW: all 4 lanes.
  - Untouched lanes are preserved.
  - A faulting store leaves memory unchanged.
- Read-after-write: a load in the cycle after a store to the same word sees the new data. Same-cycle read+write is a fault, so no RAW hazard exists inside the block.
- Fault capture: at posedge when i_reset_n & o_accessFault & !o_faultSticky, set o_faultSticky=1 and o_faultAddr=i_memAddr. Later faults do not overwrite. Only reset clears the capture.
- Counters: at posedge when i_reset_n & !fault, o_readCount increments on a read and o_writeCount increments on a write. Both are 32-bit and wrap from FFFF_FFFF to 0.
- Reset asserted mid-sequence: counters and fault state clear on that edge. Memory keeps its prior contents.

Optional Feature:
- DMEM_COUNTERS_EN
  - Defined: o_readCount and o_writeCount behave as specified above.
  - Undefined: no counter registers are built; both outputs are tied to 32'h0.
  - All other behaviour is identical in both builds.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF; next cycle LW 0x10 → readData 0xDEADBEEF, writeCount=1, readCount=1.
- After the above, SB 0x11 data 0x0000_0055; then LW 0x10 → 0xDEAD55EF. Then LB 0x11 → 0x00000055. Then LB 0x13 → 0xFFFFFFDE. Then LBU 0x13 → 0x000000DE.
- SH 0x22 data 0x8001; LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001; LW 0x20 → upper half 0x8001, lower half unchanged.
- LW 0x13 (misaligned) → accessFault=1, readData=0, faultSticky=1, faultAddr=0x13, readCount unchanged. Then SW 0x2000 (out of range at default depth) → fault, no write, faultAddr stays 0x13.
- ctrl=11 at 0x40 → fault and no store. funct3=011 load → fault, readData 0. Reset → sticky 0, counters 0, a subsequent LW 0x10 still returns 0xDEAD55EF.
- DMEM_COUNTERS_EN defined, with counters force-preloaded to 32'hFFFF_FFFF → one LW → readCount=0. Build without the macro → counters read 0 after 5 stores.

Source files
------------

// File: rtl/mem_dmem.sv
// RV32 MEM-stage data memory: combinational sized loads, clocked byte-enabled stores, sticky fault capture.
// Optional build macro DMEM_COUNTERS_EN adds the load/store access counters; otherwise they read as zero.
module mem_dmem #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_memAddr,
    input  logic [31:0] i_writeData,
    input  logic [1:0]  i_ctrlMEM,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_readData,
    output logic        o_accessFault,
    output logic        o_faultSticky,
    output logic [31:0] o_faultAddr,
    output logic [31:0] o_readCount,
    output logic [31:0] o_writeCount
);

    localparam int          ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic is_signed);
        logic signed [7:0]  sb;
        logic signed [31:0] sx;
        sb = signed'(b);
        sx = sb;
        return is_signed ? 32'(sx) : {24'h0, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic is_signed);
        logic signed [15:0] sh;
        logic signed [31:0] sx;
        sh = signed'(h);
        sx = sh;
        return is_signed ? 32'(sx) : {16'h0, h};
    endfunction

    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       offset;
    logic [ADDR_W-1:0] word_idx;
    logic              rd, wr, in_range, ld_legal, st_legal, misaligned;
    logic [31:0]       rd_word, load_val, wr_lanes;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [3:0]        byte_en;
    logic              commit;

    // BASE_ADDR is word aligned, so offset[1:0] is the byte lane.
    assign rd       = i_ctrlMEM[1];
    assign wr       = i_ctrlMEM[0];
    assign offset   = i_memAddr - BASE_ADDR;
    assign in_range = offset < SPAN;
    assign word_idx = offset[ADDR_W+1:2];

    always_comb begin
        ld_legal = 1'b0;
        case (i_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_legal = 1'b1;
            default:                                ld_legal = 1'b0;
        endcase
        st_legal   = !i_funct3[2] && (i_funct3[1:0] != 2'b11);
        misaligned = ((i_funct3[1:0] == 2'b01) && offset[0]) ||
                     ((i_funct3[1:0] == 2'b10) && (offset[1:0] != 2'b00));
        o_accessFault = (rd || wr) &&
                        (!in_range || (rd && !ld_legal) || (wr && !st_legal) ||
                         misaligned || (rd && wr));
    end

    assign rd_word = mem[word_idx];
    assign byte_v  = rd_word[{offset[1:0], 3'b000} +: 8];
    assign half_v  = rd_word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        load_val = 32'h0;
        case (i_funct3)
            3'b000:  load_val = ext_byte(byte_v, 1'b1);
            3'b001:  load_val = ext_half(half_v, 1'b1);
            3'b010:  load_val = rd_word;
            3'b100:  load_val = ext_byte(byte_v, 1'b0);
            3'b101:  load_val = ext_half(half_v, 1'b0);
            default: load_val = 32'h0;
        endcase
        o_readData = (rd && !o_accessFault) ? load_val : 32'h0;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en  = 4'b1111;
        wr_lanes = i_writeData;
        case (i_funct3[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << offset[1:0];
                wr_lanes = {4{i_writeData[7:0]}};
            end
            2'b01: begin
                byte_en  = offset[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{i_writeData[15:0]}};
            end
            default: begin
                byte_en  = 4'b1111;
                wr_lanes = i_writeData;
            end
        endcase
    end

    assign commit = i_reset_n && wr && !o_accessFault;

    always_ff @(posedge i_clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][i*8 +: 8] <= wr_lanes[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_faultSticky <= 1'b0;
            o_faultAddr   <= 32'h0;
        end else if (o_accessFault && !o_faultSticky) begin
            o_faultSticky <= 1'b1;
            o_faultAddr   <= i_memAddr;
        end
    end

`ifdef DMEM_COUNTERS_EN
    logic [31:0] read_cnt, write_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            read_cnt  <= 32'h0;
            write_cnt <= 32'h0;
        end else if (!o_accessFault) begin
            if (rd) read_cnt  <= read_cnt + 32'd1;
            if (wr) write_cnt <= write_cnt + 32'd1;
        end
    end

    assign o_readCount  = read_cnt;
    assign o_writeCount = write_cnt;
`else
    assign o_readCount  = 32'h0;
    assign o_writeCount = 32'h0;
`endif

endmodule
